// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam int SUB_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the column borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first through one full-subtractor cell; W cycles per result.
// start is honoured only in IDLE or DONE, so back-to-back operations cost W+1 cycles.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = SUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int CW = $clog2(W);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sr_q, a_sr_d;
    logic [W-1:0]   b_sr_q, b_sr_d;
    logic [W-1:0]   r_sr_q, r_sr_d;
    logic           borrow_q, borrow_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           a_msb_q, a_msb_d;
    logic           b_msb_q, b_msb_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           bout_q, bout_d;
    logic           ovf_q, ovf_d;

    logic           cell_d;
    logic           cell_bout;
    logic [W-1:0]   r_shift;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign r_shift = {cell_d, r_sr_q[W-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        r_sr_d   = r_sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                r_sr_d   = r_shift;
                borrow_d = cell_bout;
                if (cnt_q == CW'(W - 1)) begin
                    // Last bit: publish the result; the counter holds rather than wrapping.
                    state_d = ST_DONE;
                    diff_d  = r_shift;
                    bout_d  = cell_bout;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d  = ST_SHIFT;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    r_sr_d   = '0;
                    a_msb_d  = a[W-1];
                    b_msb_d  = b[W-1];
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            r_sr_q   <= r_sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: W=8 directed vectors plus W=4 exhaustive sweep.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bo;
        logic       ov;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;
    logic       busy4, done4, bo4, ov4;
    logic [3:0] diff4;

    exp_t q8[$];
    exp_t q4[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   zreq = 0, zseen = 0;
    int   toreq = 0, toseen = 0;
    int   bc8 = 0, bc4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
    );

    serial_subtractor #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: the only process that counts comparisons.
    always @(negedge clk) begin
        exp_t e;
        if (zreq != zseen) begin
            zseen = zreq;
            chk("idle_busy", {31'd0, busy8}, 0);
            chk("idle_done", {31'd0, done8}, 0);
            chk("idle_diff", {24'd0, diff8}, 0);
            chk("idle_borrow", {31'd0, bo8}, 0);
            chk("idle_overflow", {31'd0, ov8}, 0);
        end
        if (toreq != toseen) begin
            toseen = toreq;
            tests++;
            fails++;
            $display("FAIL timeout: done never arrived for a pending operation (cycle %0d)", cyc);
        end
        if (rst) bc8 = 0;
        else if (busy8) bc8++;
        if (rst) bc4 = 0;
        else if (busy4) bc4++;
        if (done8) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done8: done with no pending operation (cycle %0d)", cyc);
            end else begin
                e = q8.pop_front();
                chk("diff8", {24'd0, diff8}, {24'd0, e.diff});
                chk("borrow8", {31'd0, bo8}, {31'd0, e.bo});
                chk("overflow8", {31'd0, ov8}, {31'd0, e.ov});
                chk("done_cycle8", cyc, e.due);
                chk("busy_len8", bc8, 8);
            end
            bc8 = 0;
        end
        if (done4) begin
            if (q4.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done4: done with no pending operation (cycle %0d)", cyc);
            end else begin
                e = q4.pop_front();
                chk("diff4", {28'd0, diff4}, {24'd0, e.diff});
                chk("borrow4", {31'd0, bo4}, {31'd0, e.bo});
                chk("overflow4", {31'd0, ov4}, {31'd0, e.ov});
                chk("done_cycle4", cyc, e.due);
                chk("busy_len4", bc4, 4);
            end
            bc4 = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] dv, input logic bov, input logic ovv);
        exp_t e;
        e.diff = dv;
        e.bo   = bov;
        e.ov   = ovv;
        e.due  = cyc + 1 + 8;
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        q8.push_back(e);
        tick();
        start8 = 1'b0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) tick();
        if (q8.size() != 0) begin
            toreq++;
            q8.delete();
        end
        tick();
    endtask

    task automatic drain4();
        for (int i = 0; i < 30 && q4.size() != 0; i++) tick();
        if (q4.size() != 0) begin
            toreq++;
            q4.delete();
        end
        tick();
    endtask

    initial begin
        exp_t e;
        int   k;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        tick();
        tick();
        rst = 1'b0;
        zreq++;
        tick();
        zreq++;
        tick();

        issue8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0); drain8();
        issue8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0); drain8();
        issue8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1); drain8();
        issue8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0); drain8();
        issue8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1); drain8();

        // start held high; operands change mid-SHIFT and are picked up only in DONE.
        k = cyc + 1;
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        e.diff = 8'h02; e.bo = 1'b0; e.ov = 1'b0; e.due = k + 8;
        q8.push_back(e);
        tick();
        tick();
        tick();
        a8 = 8'h10; b8 = 8'h01;
        repeat (6) tick();
        e.diff = 8'h0F; e.bo = 1'b0; e.ov = 1'b0; e.due = k + 8 + 9;
        q8.push_back(e);
        tick();
        start8 = 1'b0;
        drain8();

        // Reset during the 4th SHIFT cycle discards the operation.
        a8 = 8'hFF; b8 = 8'h0F; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        zreq++;
        tick();
        zreq++;
        tick();
        issue8(8'h10, 8'h10, 8'h00, 1'b0, 1'b0); drain8();

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                int sa, sb, r;
                sa = (ai > 7) ? ai - 16 : ai;
                sb = (bi > 7) ? bi - 16 : bi;
                r  = sa - sb;
                e.diff = 8'((ai - bi) & 15);
                e.bo   = (ai < bi);
                e.ov   = (r > 7) || (r < -8);
                e.due  = cyc + 1 + 4;
                a4 = 4'(ai);
                b4 = 4'(bi);
                start4 = 1'b1;
                q4.push_back(e);
                tick();
                start4 = 1'b0;
                drain4();
            end
        end

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
